arb_mux_n: RTL and testbench
============================

// Module: arb_mux_n
// PURPOSE
//  Parametrised CH-to-1 datapath selector with valid/ready handshakes and a registered output.
//  Generalises the combinational 16:1 operand mux: any channel count, and two modes.
//   - Fixed mode: channel chosen by S.
//   - Round-robin mode: arbitrates among valid channels.
//  Sits between register-file/ALU sources and the shared result bus of the processor datapath.
// PARAMETERS
//  N     8               data width per channel, bits
//  CH    16              channel count, 2..64
//  SELW  $clog2(CH)      select/pointer width (derived; do not override)
// PORTS
//  CLK    in   1      single clock; all state updates on rising edge
//  RST    in   1      synchronous, active-high reset
//  I      in   CH*N   flattened channel data; channel k = I[k*N +: N]
//  IV     in   CH     per-channel valid
//  IR     out  CH     per-channel ready (combinational); transfer on IV[k]&IR[k]
//  S      in   SELW   channel select, fixed mode only
//  MODE   in   1      0 = fixed (S), 1 = round-robin
//  O      out  N      registered output data
//  O_VLD  out  1      output valid
//  O_RDY  in   1      downstream ready; output transfer on O_VLD&O_RDY
//  TXCNT  out  16     output transfer count (ARB_MUX_CNT_EN only)
// BEHAVIOUR
//  Reset (RST=1 at edge): O=0, O_VLD=0, ptr=0, TXCNT=0, state=EMPTY.
//    - IR=0 while RST=1.
//    - Reset overrides any transfer in the same cycle; held data is discarded.
//  States:
//    - EMPTY (O_VLD=0).
//    - FULL (O_VLD=1).
//    - EMPTY->FULL on accept.
//    - FULL->EMPTY on O_RDY with no accept.
//    - FULL->FULL on O_RDY with accept (back-to-back).
//  can_load = !O_VLD | O_RDY. At most one IR bit is high per cycle, only when can_load.
//  Fixed mode:
//    - gnt=S; IR[S]=can_load.
//    - S>=CH (CH not power of 2) -> no grant, IR all 0, no state change.
//  Round-robin mode:
//    - gnt = first k with IV[k]=1, scanning ptr, ptr+1, ..., CH-1, 0, ..., ptr-1.
//    - No valid channel -> no grant.
//    - After each accept, ptr <= gnt+1; wraps CH-1 -> 0 (explicit compare, not modulo 2^SELW).
//    - ptr is unchanged in fixed mode.
//  Accept (IV[gnt]&IR[gnt]): O <= I[gnt], O_VLD <= 1, at the next edge. Latency 1 cycle.
//    Sustained throughput is 1 word/cycle.
//  Held O is stable while O_VLD & !O_RDY; S/MODE/I changes do not affect it.
//  MODE and S are sampled only in accept cycles. A mode change mid-hold takes effect on the next accept.
//  IR never depends on O_VLD of other channels. IR depends combinationally on O_RDY (no skid buffer).
// CONFIGURATION
//  Macro ARB_MUX_CNT_EN:
//    - Defined: TXCNT port present.
//    - TXCNT increments on each O_VLD&O_RDY, saturates at 16'hFFFF, and is cleared by RST.
//    - Undefined: TXCNT port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package arb_mux_pkg:
//    - Localparams MODE_FIXED=1'b0, MODE_RR=1'b1.
//    - State encoding ST_EMPTY/ST_FULL.
//    - CNT_W=16 and CNT_MAX.
//  Sub-module rr_pick #(CH): combinational rotating priority finder.
//    - Inputs: req[CH], ptr[SELW].
//    - Outputs: gnt[SELW], any.
//  Top holds the output register, ptr, FSM, IR decode and optional counter.
// TESTING
//  1. Reset: RST=1 for 2 cycles with IV=all-1 -> O=0, O_VLD=0, IR=0, TXCNT=0.
//  2. Fixed, CH=16, N=8: S=5, IV[5]=1, I5=8'hA5, O_RDY=1 -> IR[5]=1; next cycle O=A5, O_VLD=1.
//  3. Backpressure: O_VLD=1, O_RDY=0 for 3 cycles with changing I5/S -> O holds A5, IR=0.
//     Then O_RDY=1 -> IR[5]=1, new word loaded the same edge.
//  4. RR wrap: IV={ch0,ch3,ch15}, ptr=0, O_RDY=1 -> grants 0,3,15,0 on consecutive cycles.
//     ptr wraps 15->0.
//  5. CH=10: fixed S=12 -> IR=0, O_VLD unchanged. RR grant after ch9 wraps ptr to 0, not 10.
//  6. ARB_MUX_CNT_EN: 70000 back-to-back transfers -> TXCNT=16'hFFFF, stays there.
//     Then RST -> TXCNT=0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux_n channel selector: mode codes,
// output-register state encoding and transfer-counter sizing.
package arb_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int             CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority finder: returns the first requesting channel found when
// scanning upward from ptr and wrapping at CH-1 back to channel 0.
module rr_pick #(
  parameter  int CH   = 16,
  localparam int SELW = $clog2(CH)
) (
  input  logic [CH-1:0]   req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] gnt_o,
  output logic            any_o
);

  int idx;

  // Scan from the farthest offset down to offset 0 so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int off = CH - 1; off >= 0; off--) begin
      idx = int'(ptr_i) + off;
      if (idx >= CH) idx = idx - CH;
      if (req_i[SELW'(idx)]) begin
        gnt_o = SELW'(idx);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// CH-to-1 selector with valid/ready handshakes and a registered output.
// Fixed mode picks the channel on s_i; round-robin mode arbitrates among
// valid channels starting at an internal pointer.
// Optional feature: define ARB_MUX_CNT_EN to add the saturating txcnt_o
// output-transfer counter.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int CH   = 16,
  localparam int SELW = $clog2(CH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [CH*N-1:0] i_i,
  input  logic [CH-1:0]   iv_i,
  output logic [CH-1:0]   ir_o,
  input  logic [SELW-1:0] s_i,
  input  logic            mode_i,
  output logic [N-1:0]    o_o,
  output logic            o_vld_o,
  input  logic            o_rdy_i
`ifdef ARB_MUX_CNT_EN
  ,output logic [CNT_W-1:0] txcnt_o
`endif
);

  state_e          state_q;
  logic [N-1:0]    data_q;
  logic [SELW-1:0] ptr_q;
  logic [SELW-1:0] ptr_d;
  logic [SELW-1:0] rrGnt;
  logic [SELW-1:0] gnt;
  logic            rrAny;
  logic            haveGnt;
  logic            canLoad;
  logic            accept;
  logic [N-1:0]    dataSel;

  rr_pick #(.CH(CH)) uPick (
    .req_i (iv_i),
    .ptr_i (ptr_q),
    .gnt_o (rrGnt),
    .any_o (rrAny)
  );

  assign canLoad = (state_q == ST_EMPTY) | o_rdy_i;
  assign accept  = |(ir_o & iv_i);
  assign o_o     = data_q;
  assign o_vld_o = (state_q == ST_FULL);

  // Choose the candidate channel; an out-of-range select in fixed mode grants nothing.
  always_comb begin
    gnt     = s_i;
    haveGnt = (int'(s_i) < CH);
    if (mode_i != MODE_FIXED) begin
      gnt     = rrGnt;
      haveGnt = rrAny;
    end
  end

  // One-hot ready decode and data mux for the granted channel; ready is held low in reset.
  always_comb begin
    ir_o    = '0;
    dataSel = '0;
    for (int k = 0; k < CH; k++) begin
      if (gnt == SELW'(k)) begin
        ir_o[k] = haveGnt & canLoad & ~rst_i;
        dataSel = i_i[k*N +: N];
      end
    end
  end

  // Pointer advances past the winner on round-robin accepts, wrapping explicitly at CH-1.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && (mode_i == MODE_RR)) begin
      ptr_d = (gnt == SELW'(CH - 1)) ? '0 : gnt + 1'b1;
    end
  end

  // Output register FSM: EMPTY fills on accept, FULL drains on o_rdy_i or reloads back-to-back.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q <= ST_FULL;
            data_q  <= dataSel;
          end
        end
        ST_FULL: begin
          if (accept) begin
            data_q <= dataSel;
          end else if (o_rdy_i) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

`ifdef ARB_MUX_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Count completed output transfers, sticking at the maximum value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (o_vld_o && o_rdy_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign txcnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: a 16-channel instance driven through a
// scoreboard of expected output words, plus a 10-channel instance for the
// non-power-of-two select and pointer-wrap cases. Counter checks run when
// ARB_MUX_CNT_EN is defined.
module tb_arb_mux_n;

  logic          clk;
  logic          rst;

  logic [127:0]  i16;
  logic [15:0]   iv16;
  logic [15:0]   ir16;
  logic [3:0]    s16;
  logic          mode16;
  logic [7:0]    o16;
  logic          ovld16;
  logic          ordy16;

  logic [79:0]   i10;
  logic [9:0]    iv10;
  logic [9:0]    ir10;
  logic [3:0]    s10;
  logic          mode10;
  logic [7:0]    o10;
  logic          ovld10;
  logic          ordy10;

`ifdef ARB_MUX_CNT_EN
  logic [15:0]   txcnt16;
  logic [15:0]   txcnt10;
`endif

  int            compared;
  int            mismatched;
  logic [7:0]    sbQ[$];

  arb_mux_n #(.N(8), .CH(16)) dut16 (
    .clk_i   (clk),
    .rst_i   (rst),
    .i_i     (i16),
    .iv_i    (iv16),
    .ir_o    (ir16),
    .s_i     (s16),
    .mode_i  (mode16),
    .o_o     (o16),
    .o_vld_o (ovld16),
    .o_rdy_i (ordy16)
`ifdef ARB_MUX_CNT_EN
    ,.txcnt_o (txcnt16)
`endif
  );

  arb_mux_n #(.N(8), .CH(10)) dut10 (
    .clk_i   (clk),
    .rst_i   (rst),
    .i_i     (i10),
    .iv_i    (iv10),
    .ir_o    (ir10),
    .s_i     (s10),
    .mode_i  (mode10),
    .o_o     (o10),
    .o_vld_o (ovld10),
    .o_rdy_i (ordy10)
`ifdef ARB_MUX_CNT_EN
    ,.txcnt_o (txcnt10)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] chanWord(input int k, input int salt);
    return 8'((k * 37 + salt * 11) ^ 90);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] iv, input logic [3:0] s, input logic mode, input logic ordy);
    iv16   = iv;
    s16    = s;
    mode16 = mode;
    ordy16 = ordy;
  endtask

  task automatic applyStimulus10(input logic [9:0] iv, input logic [3:0] s, input logic mode, input logic ordy);
    iv10   = iv;
    s10    = s;
    mode10 = mode;
    ordy10 = ordy;
  endtask

  task automatic fillData16(input int salt);
    for (int k = 0; k < 16; k++) i16[k*8 +: 8] = chanWord(k, salt);
  endtask

  task automatic fillData10(input int salt);
    for (int k = 0; k < 10; k++) i10[k*8 +: 8] = chanWord(k, salt);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles with every channel requesting; held data is discarded.
  task automatic doReset;
    rst = 1'b1;
    applyStimulus(16'hFFFF, 4'd0, 1'b0, 1'b1);
    applyStimulus10(10'h3FF, 4'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstIr16", 32'(ir16), 32'h0);
    checkOutput("rstVld16", 32'(ovld16), 32'h0);
    checkOutput("rstData16", 32'(o16), 32'h0);
    checkOutput("rstIr10", 32'(ir10), 32'h0);
    checkOutput("rstVld10", 32'(ovld10), 32'h0);
`ifdef ARB_MUX_CNT_EN
    checkOutput("rstCnt16", 32'(txcnt16), 32'h0);
    checkOutput("rstCnt10", 32'(txcnt10), 32'h0);
`endif
    sbQ.delete();
    tick;
    rst = 1'b0;
    applyStimulus(16'h0000, 4'd0, 1'b0, 1'b1);
    applyStimulus10(10'h000, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic drain;
    applyStimulus(16'h0000, 4'd0, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      tick;
    end
    checkOutput("sbDrained", 32'(sbQ.size()), 32'h0);
  endtask

  // Scoreboard consumer: each output transfer of the 16-channel instance pops one expected word.
  always @(negedge clk) begin
    if (!rst && ovld16 && ordy16) begin
      if (sbQ.size() > 0) begin
        checkOutput("sbData", 32'(o16), 32'(sbQ.pop_front()));
      end else begin
        checkOutput("sbUnderflow", 32'(sbQ.size()), 32'h1);
      end
    end
  end

  initial begin
    int         rrG[5];
    int         g10[5];
    logic [7:0] prev10;
    int         mPtr;
    logic       mFull;
    logic       mFullNext;
    logic       mAny;
    int         mG;
    int         idx;
    logic [15:0] expIr;
    logic       ivR;
    logic       modeR;
    logic       ordyR;
    logic [3:0] sR;

    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    i16        = '0;
    i10        = '0;
    applyStimulus(16'hFFFF, 4'd0, 1'b0, 1'b1);
    applyStimulus10(10'h3FF, 4'd0, 1'b0, 1'b1);
    #1;
    doReset();

    // Fixed mode: channel 5 carries A5.
    fillData16(1);
    i16[5*8 +: 8] = 8'hA5;
    applyStimulus(16'h0020, 4'd5, 1'b0, 1'b1);
    sbQ.push_back(8'hA5);
    @(negedge clk);
    checkOutput("fixIr", 32'(ir16), 32'h0020);
    checkOutput("fixVldBefore", 32'(ovld16), 32'h0);
    tick;

    // Backpressure: data and select wander while the output is held.
    for (int c = 0; c < 3; c++) begin
      fillData16(10 + c);
      applyStimulus(16'h0020, 4'(c + 6), 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("holdData", 32'(o16), 32'hA5);
      checkOutput("holdVld", 32'(ovld16), 32'h1);
      checkOutput("holdIr", 32'(ir16), 32'h0);
      tick;
    end
    fillData16(20);
    i16[5*8 +: 8] = 8'h3C;
    applyStimulus(16'h0020, 4'd5, 1'b0, 1'b1);
    sbQ.push_back(8'h3C);
    @(negedge clk);
    checkOutput("releaseIr", 32'(ir16), 32'h0020);
    tick;
    applyStimulus(16'h0000, 4'd5, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("b2bData", 32'(o16), 32'h3C);
    checkOutput("b2bVld", 32'(ovld16), 32'h1);
    tick;
    @(negedge clk);
    checkOutput("emptyVld", 32'(ovld16), 32'h0);
    tick;

    // Round-robin over channels 0, 3 and 15 with the pointer wrapping 15 -> 0.
    rrG = '{0, 3, 15, 0, 3};
    for (int c = 0; c < 5; c++) begin
      fillData16(30 + c);
      applyStimulus(16'h8009, 4'd0, 1'b1, 1'b1);
      sbQ.push_back(chanWord(rrG[c], 30 + c));
      @(negedge clk);
      checkOutput("rrIr", 32'(ir16), 32'(16'(1) << rrG[c]));
      tick;
    end
    drain();

    // Random mix of modes, requests and backpressure against a reference model.
    doReset();
    mPtr  = 0;
    mFull = 1'b0;
    for (int c = 0; c < 300; c++) begin
      modeR = 1'($urandom_range(0, 1));
      sR    = 4'($urandom_range(0, 15));
      ordyR = ($urandom_range(0, 3) != 0);
      fillData16(int'($urandom_range(0, 255)));
      applyStimulus(16'($urandom) & 16'($urandom), sR, modeR, ordyR);
      mAny = 1'b0;
      mG   = 0;
      if (modeR) begin
        for (int off = 0; off < 16; off++) begin
          idx = (mPtr + off) % 16;
          if (!mAny && iv16[idx]) begin
            mAny = 1'b1;
            mG   = idx;
          end
        end
      end else begin
        mAny = 1'b1;
        mG   = int'(sR);
      end
      expIr     = (mAny && (!mFull || ordyR)) ? (16'(1) << mG) : 16'h0;
      ivR       = iv16[mG];
      mFullNext = mFull;
      if ((expIr != 16'h0) && ivR) begin
        sbQ.push_back(i16[mG*8 +: 8]);
        mFullNext = 1'b1;
        if (modeR) mPtr = (mG == 15) ? 0 : mG + 1;
      end else if (ordyR) begin
        mFullNext = 1'b0;
      end
      @(negedge clk);
      checkOutput("randIr", 32'(ir16), 32'(expIr));
      checkOutput("randVld", 32'(ovld16), 32'(mFull));
      mFull = mFullNext;
      tick;
    end
    drain();

    // Ten channels: select 12 is out of range and grants nothing.
    fillData10(40);
    applyStimulus10(10'h3FF, 4'd12, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("oorIrEmpty", 32'(ir10), 32'h0);
    checkOutput("oorVldEmpty", 32'(ovld10), 32'h0);
    tick;
    i10[2*8 +: 8] = 8'h5A;
    applyStimulus10(10'h3FF, 4'd2, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ch10Ir", 32'(ir10), 32'h004);
    tick;
    fillData10(41);
    applyStimulus10(10'h3FF, 4'd12, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("oorHoldData", 32'(o10), 32'h5A);
    checkOutput("oorHoldVld", 32'(ovld10), 32'h1);
    checkOutput("oorHoldIr", 32'(ir10), 32'h0);
    tick;
    applyStimulus10(10'h3FF, 4'd12, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("oorRdyIr", 32'(ir10), 32'h0);
    tick;

    // Round-robin on ten channels: granting channel 9 must wrap the pointer to 0.
    g10 = '{9, 0, 9, 0, 9};
    prev10 = 8'h00;
    for (int c = 0; c < 5; c++) begin
      fillData10(50 + c);
      applyStimulus10((c == 0) ? 10'h200 : 10'h201, 4'd0, 1'b1, 1'b1);
      @(negedge clk);
      if (c == 0) checkOutput("rr10VldEmpty", 32'(ovld10), 32'h0);
      else        checkOutput("rr10Data", 32'(o10), 32'(prev10));
      checkOutput("rr10Ir", 32'(ir10), 32'(10'(1) << g10[c]));
      prev10 = chanWord(g10[c], 50 + c);
      tick;
    end
    applyStimulus10(10'h000, 4'd0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("rr10Last", 32'(o10), 32'(prev10));
    tick;

`ifdef ARB_MUX_CNT_EN
    // Long back-to-back run saturates the transfer counter.
    i16[5*8 +: 8] = 8'hA5;
    applyStimulus(16'hFFFF, 4'd5, 1'b0, 1'b1);
    repeat (70000) begin
      sbQ.push_back(8'hA5);
      tick;
    end
    @(negedge clk);
    checkOutput("cntSat", 32'(txcnt16), 32'hFFFF);
    tick;
    drain();
    checkOutput("cntStay", 32'(txcnt16), 32'hFFFF);
    doReset();
`endif

    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
